// File: rtl/icache_nway_ctlr_if.sv
// Fetch-side bundle of the N-way I-cache controller: tag/valid lookups, branch/flush context, refill bus.
interface icache_nway_ctlr_if #(
  parameter int S = 64,
  parameter int N = 4,
  parameter int B = 4
);
  logic [$clog2(S)-1:0] set_i;
  logic [N-1:0]         hit_way_i;
  logic [N-1:0]         valid_way_i;
  logic [1:0]           pc_src_reg_i;
  logic [1:0]           branch_op_ex_i;
  logic                 mem_rvalid_i;
  logic [S-1:0]         active_array_o;
  logic                 instr_hit_fi_o;
  logic [N-1:0]         hit_way_o;
  logic [N-1:0]         repl_way_o;
  logic                 mem_req_o;
  logic                 refill_we_o;
  logic [$clog2(B)-1:0] refill_word_o;
  logic                 tag_we_o;
  logic                 stall_fi_o;

  modport slave (
    input  set_i, hit_way_i, valid_way_i, pc_src_reg_i, branch_op_ex_i, mem_rvalid_i,
    output active_array_o, instr_hit_fi_o, hit_way_o, repl_way_o, mem_req_o,
           refill_we_o, refill_word_o, tag_we_o, stall_fi_o
  );

  modport master (
    output set_i, hit_way_i, valid_way_i, pc_src_reg_i, branch_op_ex_i, mem_rvalid_i,
    input  active_array_o, instr_hit_fi_o, hit_way_o, repl_way_o, mem_req_o,
           refill_we_o, refill_word_o, tag_we_o, stall_fi_o
  );
endinterface

// File: rtl/icache_nway_ctlr.sv
// N-way set-associative I-cache controller: hit report, victim choice and B-word refill sequencing.
// Replacement is per-set round-robin by default; define ICACHE_PLRU_EN for per-set tree pseudo-LRU.
`ifndef NON_BRANCH
`define NON_BRANCH 2'b00
`endif

module icache_nway_ctlr #(
  parameter int S = 64,
  parameter int N = 4,
  parameter int B = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  icache_nway_ctlr_if.slave bus
);
  localparam int SW = $clog2(S);
  localparam int NW = $clog2(N);
  localparam int BW = $clog2(B);

  // state   | meaning
  // IDLE    | serving hits, watching for a miss
  // BR_WAIT | miss held one cycle behind an unresolved branch in EX
  // REFILL  | memory requested, one word written per mem_rvalid_i
  // DONE    | line complete: write tag, set valid, update replacement
  typedef enum logic [1:0] {IDLE, BR_WAIT, REFILL, DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] set_q;
  logic [BW-1:0] cnt_q;
  logic [N-1:0]  repl_q;
  logic          miss, flush, branch_pend, latch_en;
  logic [N-1:0]  victim;
  logic [NW-1:0] pol_idx;
  logic [SW-1:0] cur_set;

  assign miss        = (bus.hit_way_i == '0);
  assign flush       = bus.pc_src_reg_i[1];
  assign branch_pend = (bus.branch_op_ex_i != `NON_BRANCH);
  assign cur_set     = (state_q == REFILL || state_q == DONE) ? set_q : bus.set_i;

  assign bus.active_array_o = S'(1) << cur_set;
  assign bus.instr_hit_fi_o = ~miss;
  assign bus.hit_way_o      = bus.hit_way_i;
  assign bus.repl_way_o     = repl_q;
  assign bus.refill_word_o  = cnt_q;

  // Empty ways are filled before the policy is consulted.
  always_comb begin
    logic found;
    found  = 1'b0;
    victim = '0;
    for (int w = 0; w < N; w++) begin
      if (!bus.valid_way_i[w] && !found) begin
        victim[w] = 1'b1;
        found     = 1'b1;
      end
    end
    if (!found) victim = N'(1) << pol_idx;
  end

`ifdef ICACHE_PLRU_EN
  logic [N-2:0]  plru_q [S];
  logic [N-2:0]  tree_wr;
  logic          upd_en;
  logic [SW-1:0] upd_set;
  logic [NW-1:0] upd_idx;

  // Tree node j has children 2j+1 / 2j+2; a node bit of 1 sends the victim walk right.
  always_comb begin
    int   node;
    logic dir;
    node = 0;
    for (int l = 0; l < NW; l++) begin
      dir = 1'b0;
      for (int j = 0; j < N - 1; j++) if (j == node) dir = plru_q[bus.set_i][j];
      node = 2 * node + 1 + int'(dir);
    end
    pol_idx = NW'(node - (N - 1));
  end

  always_comb begin
    upd_en  = 1'b0;
    upd_set = bus.set_i;
    upd_idx = '0;
    if (state_q == DONE) begin
      upd_en  = 1'b1;
      upd_set = set_q;
      for (int w = 0; w < N; w++) if (repl_q[w]) upd_idx = NW'(w);
    end else if (state_q == IDLE && !miss) begin
      upd_en = 1'b1;
      for (int w = 0; w < N; w++) if (bus.hit_way_i[w]) upd_idx = NW'(w);
    end
  end

  // Touching a way points every node on its path away from it.
  always_comb begin
    int            node;
    logic [NW-1:0] sh;
    tree_wr = plru_q[upd_set];
    node    = 0;
    for (int l = 0; l < NW; l++) begin
      sh = upd_idx >> (NW - 1 - l);
      for (int j = 0; j < N - 1; j++) if (j == node) tree_wr[j] = ~sh[0];
      node = 2 * node + 1 + int'(sh[0]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int s = 0; s < S; s++) plru_q[s] <= '0;
    end else if (upd_en) begin
      plru_q[upd_set] <= tree_wr;
    end
  end
`else
  logic [NW-1:0] rr_q [S];

  assign pol_idx = rr_q[bus.set_i];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int s = 0; s < S; s++) rr_q[s] <= '0;
    end else if (state_q == DONE) begin
      rr_q[set_q] <= rr_q[set_q] + 1'b1;
    end
  end
`endif

  always_comb begin
    state_d         = state_q;
    latch_en        = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.refill_we_o = 1'b0;
    bus.tag_we_o    = 1'b0;
    bus.stall_fi_o  = 1'b1;
    unique case (state_q)
      IDLE: begin
        bus.stall_fi_o = miss && !flush;
        if (miss && !flush) begin
          if (branch_pend) begin
            state_d = BR_WAIT;
          end else begin
            state_d  = REFILL;
            latch_en = 1'b1;
          end
        end
      end
      BR_WAIT: begin
        if (!flush && miss) begin
          state_d  = REFILL;
          latch_en = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      REFILL: begin
        bus.mem_req_o   = 1'b1;
        bus.refill_we_o = bus.mem_rvalid_i;
        if (bus.mem_rvalid_i && cnt_q == BW'(B - 1)) state_d = DONE;
      end
      DONE: begin
        bus.tag_we_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      set_q   <= '0;
      cnt_q   <= '0;
      repl_q  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        set_q  <= bus.set_i;
        repl_q <= victim;
      end
      if (bus.refill_we_o) cnt_q <= cnt_q + 1'b1;
    end
  end

  a_hit_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i) $onehot0(bus.hit_way_i));
endmodule
